// File: rtl/ir_pkg.sv
// Shared state encoding and protocol unit counts for the IR frame scheduler.
package ir_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GAP
  } ir_state_e;

  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int BIT_MARK_U   = 1;
  localparam int ZERO_SPACE_U = 1;
  localparam int ONE_SPACE_U  = 3;
  localparam int STOP_U       = 1;

  function automatic logic is_mark(ir_state_e s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier square wave; restart forces the high phase so every mark begins high.
module ir_carrier_gen #(
  parameter int CARRIER_DIV = 1316
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic carrier
);
  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          carrier_q, carrier_d;

  always_comb begin
    cnt_d     = cnt_q;
    carrier_d = carrier_q;
    if (restart) begin
      carrier_d = 1'b1;
      cnt_d     = CW'(CARRIER_DIV - 1);
    end else if (!enable) begin
      carrier_d = 1'b0;
      cnt_d     = '0;
    end else if (cnt_q == '0) begin
      carrier_d = ~carrier_q;
      cnt_d     = CW'(CARRIER_DIV - 1);
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      carrier_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      carrier_q <= carrier_d;
    end
  end

  assign carrier = carrier_q;

endmodule

// File: rtl/ir_frame_scheduler.sv
// NEC-style IR frame scheduler: round-robin over two requesters, LSB-first pulse-distance frames.
//   state        | meaning
//   S_IDLE       | waiting for a request
//   S_LEAD_MARK  | 16-unit leader burst
//   S_LEAD_SPACE | 8-unit leader space
//   S_BIT_MARK   | 1-unit data burst
//   S_BIT_SPACE  | 1 unit (bit 0) or 3 units (bit 1)
//   S_STOP_MARK  | 1-unit trailing burst
//   S_GAP        | inter-frame gap, done on its last cycle
module ir_frame_scheduler
  import ir_pkg::*;
#(
  parameter int UNIT_CYC    = 56250,
  parameter int CARRIER_DIV = 1316,
  parameter int GAP_UNITS   = 72
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_data,
  input  logic [9:0]  req_nbits,
  input  logic        abort,
  output logic        ir_out,
  output logic        ir_env,
  output logic        busy,
  output logic        grant_id,
  output logic        done,
  output logic        done_aborted
);
  localparam int MAX_U = (GAP_UNITS > LEAD_MARK_U) ? GAP_UNITS : LEAD_MARK_U;
  localparam int TW    = $clog2(MAX_U * UNIT_CYC);

  ir_state_e   state_q, state_d;
  logic [TW-1:0] tmr_q;
  logic [31:0] data_q;
  logic [5:0]  bits_q;
  logic        last_q, grant_id_q, aborted_q;
  logic        win, accept, tmr_zero, abort_hit, carrier;

  function automatic logic [TW-1:0] dur_cyc(ir_state_e s, logic one);
    int u;
    case (s)
      S_LEAD_MARK:  u = LEAD_MARK_U;
      S_LEAD_SPACE: u = LEAD_SPACE_U;
      S_BIT_MARK:   u = BIT_MARK_U;
      S_BIT_SPACE:  u = one ? ONE_SPACE_U : ZERO_SPACE_U;
      S_STOP_MARK:  u = STOP_U;
      S_GAP:        u = GAP_UNITS;
      default:      u = 0;
    endcase
    return (u == 0) ? '0 : TW'(u * UNIT_CYC - 1);
  endfunction

  always_comb begin
    case (req_valid)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
  end

  assign tmr_zero  = (tmr_q == '0);
  assign accept    = |req_ready;
  assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_GAP);

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (accept)   state_d = S_LEAD_MARK;
      S_LEAD_MARK:  if (tmr_zero) state_d = S_LEAD_SPACE;
      S_LEAD_SPACE: if (tmr_zero) state_d = S_BIT_MARK;
      S_BIT_MARK:   if (tmr_zero) state_d = S_BIT_SPACE;
      S_BIT_SPACE:  if (tmr_zero) state_d = (bits_q == 6'd1) ? S_STOP_MARK : S_BIT_MARK;
      S_STOP_MARK:  if (tmr_zero) state_d = S_GAP;
      S_GAP:        if (tmr_zero) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_GAP;
  end

  always_comb begin
    req_ready    = (state_q == S_IDLE && !ARESET && |req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
    ir_env       = is_mark(state_q);
    ir_out       = ir_env & carrier;
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_GAP) && tmr_zero;
    done_aborted = done & aborted_q;
    grant_id     = grant_id_q;
  end

  // data_q[0] is always the bit being sent; it is shifted out when its space ends.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      tmr_q      <= '0;
      data_q     <= '0;
      bits_q     <= '0;
      last_q     <= 1'b1;
      grant_id_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      if (state_d != state_q)     tmr_q <= dur_cyc(state_d, data_q[0]);
      else if (state_q != S_IDLE) tmr_q <= tmr_q - 1'b1;
      if (accept) begin
        data_q     <= win ? req_data[63:32] : req_data[31:0];
        bits_q     <= ((win ? req_nbits[9:5] : req_nbits[4:0]) == 5'd0) ? 6'd32
                      : {1'b0, (win ? req_nbits[9:5] : req_nbits[4:0])};
        grant_id_q <= win;
        last_q     <= win;
        aborted_q  <= 1'b0;
      end else if (abort_hit) begin
        aborted_q <= 1'b1;
      end else if (state_q == S_BIT_SPACE && tmr_zero) begin
        data_q <= {1'b0, data_q[31:1]};
        bits_q <= bits_q - 1'b1;
      end
    end
  end

  ir_carrier_gen #(.CARRIER_DIV(CARRIER_DIV)) u_carrier (
    .clk     (ACLK),
    .rst     (ARESET),
    .enable  (is_mark(state_d)),
    .restart (is_mark(state_d) && !is_mark(state_q)),
    .carrier (carrier)
  );

endmodule

// File: tb/tb_ir_frame_scheduler.sv
// Directed bench for ir_frame_scheduler with a short unit (4 cycles) and carrier half-period of 2.
module tb_ir_frame_scheduler;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_data;
  logic [9:0]  req_nbits;
  logic        abort;
  logic        ir_out, ir_env, busy, grant_id, done, done_aborted;

  int n_cmp = 0;
  int n_bad = 0;
  int n, env_cnt;

  ir_frame_scheduler #(.UNIT_CYC(4), .CARRIER_DIV(2), .GAP_UNITS(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_nbits(req_nbits), .abort(abort), .ir_out(ir_out),
    .ir_env(ir_env), .busy(busy), .grant_id(grant_id), .done(done),
    .done_aborted(done_aborted)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks one constant-envelope segment cycle by cycle, leaving the bench one cycle past it.
  task automatic check_seg(input string tag, input int len, input bit mark,
                           input bit end_done, input bit end_ab, input bit drv_abort);
    for (int i = 0; i < len; i++) begin
      abort = drv_abort;
      chk({tag, "_env"},  {63'd0, ir_env},       {63'd0, mark});
      chk({tag, "_out"},  {63'd0, ir_out},       {63'd0, mark && ((i % 4) < 2)});
      chk({tag, "_done"}, {63'd0, done},         {63'd0, end_done && (i == len - 1)});
      chk({tag, "_dab"},  {63'd0, done_aborted}, {63'd0, end_ab && (i == len - 1)});
      chk({tag, "_busy"}, {63'd0, busy},         64'd1);
      tick();
    end
    abort = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (done !== 1'b1 && cnt < limit);
  endtask

  initial begin
    ARESET = 1'b1; req_valid = 2'b01; req_data = '0; req_nbits = '0; abort = 1'b0;
    tick(); tick();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_busy",  busy, 0);
    chk("rst_env",   ir_env, 0);
    chk("rst_out",   ir_out, 0);
    chk("rst_done",  done, 0);
    chk("rst_grant", grant_id, 0);

    // Frame A: requester 0, data 0x1, 2 bits; abort held through the gap must be ignored.
    ARESET = 1'b0; req_data = 64'h0000_0000_0000_0001; req_nbits = {5'd0, 5'd2};
    #1;
    chk("a_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("a_grant", grant_id, 0);
    check_seg("a_lead_m",  64, 1, 0, 0, 0);
    check_seg("a_lead_s",  32, 0, 0, 0, 0);
    check_seg("a_b0_m",     4, 1, 0, 0, 0);
    check_seg("a_b0_s",    12, 0, 0, 0, 0);
    check_seg("a_b1_m",     4, 1, 0, 0, 0);
    check_seg("a_b1_s",     4, 0, 0, 0, 0);
    check_seg("a_stop",     4, 1, 0, 0, 0);
    check_seg("a_gap",     16, 0, 1, 0, 1);
    chk("a_idle_busy", busy, 0);

    // Frame B: sole requester 1, nbits=0 -> 32 ones, accepted the cycle after done.
    req_valid = 2'b10; req_data = 64'hFFFF_FFFF_0000_0000; req_nbits = {5'd0, 5'd0};
    #1;
    chk("b_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("b_grant", grant_id, 1);
    n = 1; env_cnt = ir_env ? 1 : 0;
    while (done !== 1'b1 && n < 2000) begin
      tick();
      n++;
      if (ir_env) env_cnt++;
    end
    chk("b_len", n, 628);
    chk("b_env_cycles", env_cnt, 196);
    chk("b_dab", done_aborted, 0);
    tick();

    // Frames C: both valid continuously after reset -> 0,1,0,1.
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0; req_valid = 2'b11; req_data = '0; req_nbits = {5'd1, 5'd1};
    for (int f = 0; f < 4; f++) begin
      #1;
      chk("c_ready", req_ready, (f % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("c_grant", grant_id, f % 2);
      n = 1;
      while (done !== 1'b1 && n < 1000) begin
        tick();
        n++;
      end
      chk("c_len", n, 124);
      tick();
    end
    req_valid = 2'b00;

    // Frame D: abort in the 3rd bit space (cycle T+118).
    req_valid = 2'b01; req_nbits = {5'd0, 5'd4};
    #1;
    chk("d_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 117; i++) tick();
    chk("d_pre_env", ir_env, 0);
    chk("d_pre_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_seg("d_gap", 16, 0, 1, 1, 0);
    chk("d_idle_busy", busy, 0);

    // Frame E: abort with acceptance is ignored; reset mid-lead restores the tie pointer.
    req_valid = 2'b01; abort = 1'b1;
    #1;
    chk("e_ready", req_ready, 2'b01);
    tick();
    abort = 1'b0; req_valid = 2'b00;
    check_seg("e_lead", 10, 1, 0, 0, 0);
    ARESET = 1'b1; req_valid = 2'b11;
    tick();
    chk("e_rst_out",   ir_out, 0);
    chk("e_rst_env",   ir_env, 0);
    chk("e_rst_busy",  busy, 0);
    chk("e_rst_done",  done, 0);
    chk("e_rst_dab",   done_aborted, 0);
    chk("e_rst_grant", grant_id, 0);
    chk("e_rst_ready", req_ready, 2'b00);
    ARESET = 1'b0;
    #1;
    chk("e_tie_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("e_tie_grant", grant_id, 0);
    chk("e_tie_env", ir_env, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ir_frame_scheduler.md
IR_FRAME_SCHEDULER -- requirements
Module: ir_frame_scheduler

Interface
REQ-001 SHALL have parameter UNIT_CYC, default 56250, meaning ACLK cycles per 562.5 us protocol unit.
REQ-002 SHALL have parameter CARRIER_DIV, default 1316, meaning ACLK cycles per carrier half-period.
REQ-003 SHALL have parameter GAP_UNITS, default 72, meaning inter-frame gap length in units.
REQ-004 SHALL have port ACLK, input, 1 bit: single clock; all logic on rising edge.
REQ-005 SHALL have port ARESET, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 2 bits: frame request per requester (0 = software register, 1 = auto-repeat).
REQ-007 SHALL have port req_ready, output, 2 bits: request accepted in the cycle where valid and ready are both high.
REQ-008 SHALL have port req_data, input, 64 bits: frame payload, requester i in bits [32i+31:32i].
REQ-009 SHALL have port req_nbits, input, 10 bits: bit count, requester i in bits [5i+4:5i]; 0 means 32.
REQ-010 SHALL have port abort, input, 1 bit: terminate the current frame.
REQ-011 SHALL have port ir_out, output, 1 bit: carrier-modulated IR drive.
REQ-012 SHALL have port ir_env, output, 1 bit: unmodulated mark envelope.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port grant_id, output, 1 bit: requester owning the current or last frame.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.
REQ-016 SHALL have port done_aborted, output, 1 bit: qualifies done; high if the frame was aborted.

Function
REQ-017 SHALL implement states IDLE, LEAD_MARK (16 units), LEAD_SPACE (8), BIT_MARK (1), BIT_SPACE (1 for bit 0, 3 for bit 1), STOP_MARK (1), and GAP (GAP_UNITS); each state lasts exactly units*UNIT_CYC cycles.
REQ-018 SHALL assert req_ready only in IDLE with ARESET low, and only toward the arbitration winner; the other bit SHALL be 0.
REQ-019 SHALL arbitrate round-robin: a sole valid requester wins; on a tie, the requester not granted last wins; the last-grant pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-020 SHALL latch the payload, nbits and grant_id on acceptance at cycle T, and enter LEAD_MARK at T+1.
REQ-021 SHALL transmit data bits LSB first, BIT_MARK then BIT_SPACE per bit; after the last bit it SHALL go to STOP_MARK, then GAP, then IDLE.
REQ-022 SHALL hold ir_env high exactly during the mark states (LEAD_MARK, BIT_MARK, STOP_MARK) and low otherwise.
REQ-023 During marks, ir_out SHALL start high on the first mark cycle and toggle every CARRIER_DIV cycles; the carrier phase SHALL restart at each mark; ir_out SHALL be 0 outside marks.
REQ-024 SHALL pulse done in the final GAP cycle; IDLE follows the next cycle, so the earliest next acceptance is the cycle after done.
REQ-025 abort sampled high in LEAD_MARK through STOP_MARK SHALL force GAP on the next cycle, with ir_out and ir_env low, a full GAP_UNITS gap, and done_aborted=1 alongside done.
REQ-026 abort SHALL be ignored in IDLE and GAP; abort in the same cycle as an acceptance SHALL be ignored.
REQ-027 Counter widths SHALL be derived from the parameters with $clog2 and SHALL NOT wrap within a state.

Reset
REQ-028 ARESET high SHALL, on the next edge, force state IDLE, clear all counters, set ir_out, ir_env, busy, done, done_aborted and grant_id to 0, and set the last-grant pointer to 1; reset mid-frame SHALL truncate the frame without a done pulse.

Structure
REQ-029 Package ir_pkg SHALL hold the state enum and the unit constants (LEAD_MARK_U=16, LEAD_SPACE_U=8, BIT_MARK_U=1, ZERO_SPACE_U=1, ONE_SPACE_U=3, STOP_U=1).
REQ-030 The carrier toggle logic SHALL be the sub-module ir_carrier_gen (inputs: enable and restart; output: carrier).

Verification (UNIT_CYC=4, CARRIER_DIV=2, GAP_UNITS=4)
REQ-031 Requester 0 sends data=0x1, nbits=2, accepted at T -> ir_env high T+1..T+64; bit 1 space 12 cycles; bit 0 space 4 cycles; done at T+140; IDLE at T+141.
REQ-032 Both valid continuously after reset -> grant order 0,1,0,1, with grant_id matching each frame.
REQ-033 nbits=0, data=0xFFFFFFFF -> 32 one-bits; frame length (24+128+1+4)*4 = 628 cycles.
REQ-034 abort pulsed during the 3rd BIT_SPACE -> ir_env 0 next cycle; GAP of 16 cycles; done=1 and done_aborted=1.
REQ-035 ARESET asserted mid-LEAD_MARK -> next cycle all outputs 0, no done pulse, and the first tie afterwards is won by requester 0.
REQ-036 During LEAD_MARK -> ir_out pattern 1,1,0,0 repeating for 64 cycles, restarting high at each BIT_MARK.
